// File: rtl/rr_onehot_arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter slice.
package rr_onehot_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage : rr_onehot_arb_pkg

// File: rtl/rr_onehot_arb_pick.sv
// Combinational round-robin pick: lowest set request at or after ptr, wrapping circularly.
module rr_onehot_pick #(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   win,
    output logic                 any
);

    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;

    // Lower half holds requests at/after ptr, upper half the full vector,
    // so the first set bit of dbl is the circular winner.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
        dbl   = {req, req & mask};
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && dbl[i]) begin
                found              = 1'b1;
                win[i % NUM_REQ]   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule : rr_onehot_pick

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with registered one-hot grant held across consumer stalls.
module rr_onehot_arb
    import rr_onehot_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o,
    input  logic               ready_i
);

    typedef logic [IDX_WIDTH-1:0] ptr_t;

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    ptr_t               ptr_q;

    logic [NUM_REQ-1:0] win;
    logic               any;
    ptr_t               win_idx;
    ptr_t               ptr_nxt;

    rr_onehot_pick #(
        .NUM_REQ  (NUM_REQ),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_pick (
        .req(req_i),
        .ptr(ptr_q),
        .win(win),
        .any(any)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = ptr_t'(i);
        end
        ptr_nxt = (win_idx == ptr_t'(NUM_REQ - 1)) ? '0 : win_idx + ptr_t'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
        end else if (state_q == ST_IDLE || ready_i) begin
            if (any) begin
                state_q <= ST_HOLD;
                gnt_q   <= win;
                ptr_q   <= ptr_nxt;
            end else begin
                state_q <= ST_IDLE;
                gnt_q   <= '0;
            end
        end
    end

    assign gnt_o   = gnt_q;
    assign valid_o = (state_q == ST_HOLD);

`ifndef SYNTHESIS
    a_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_valid_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni) valid_o |-> |gnt_o);
    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> $stable(gnt_o));
`endif

endmodule : rr_onehot_arb

// File: tb/tb_rr_onehot_arb.sv
// Scoreboard bench for rr_onehot_arb (NUM_REQ=8 and NUM_REQ=5 instances).
module tb_rr_onehot_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] req8 = 8'h00;
    logic [4:0] req5 = 5'h00;
    logic       rdy8 = 1'b0;
    logic       rdy5 = 1'b0;
    logic [7:0] gnt8;
    logic [4:0] gnt5;
    logic       val8, val5;

    always #5 clk = ~clk;

    rr_onehot_arb #(.NUM_REQ(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_i(req8),
        .gnt_o(gnt8), .valid_o(val8), .ready_i(rdy8)
    );

    rr_onehot_arb #(.NUM_REQ(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .req_i(req5),
        .gnt_o(gnt5), .valid_o(val5), .ready_i(rdy5)
    );

    typedef struct {
        logic       v8;
        logic [7:0] g8;
        logic       v5;
        logic [4:0] g5;
        int         idx5;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    // Reference model: per-instance grant flag, winner index, priority pointer.
    bit m_val[2];
    int m_win[2];
    int m_ptr[2];

    function automatic void model_step(int m, int n, bit rst, bit fl, int unsigned req, bit rdy);
        if (!rst) begin
            m_val[m] = 1'b0; m_ptr[m] = 0; m_win[m] = 0;
        end else if (fl) begin
            m_val[m] = 1'b0;
        end else if (!m_val[m] || rdy) begin
            m_val[m] = 1'b0;
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = (m_ptr[m] + k) % n;
                if (!m_val[m] && ((req >> idx) & 1) == 1) begin
                    m_val[m] = 1'b1;
                    m_win[m] = idx;
                end
            end
            if (m_val[m]) m_ptr[m] = (m_win[m] + 1) % n;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.v8   = m_val[0];
        e.g8   = m_val[0] ? 8'(1 << m_win[0]) : 8'h00;
        e.v5   = m_val[1];
        e.g5   = m_val[1] ? 5'(1 << m_win[1]) : 5'h00;
        e.idx5 = m_win[1];
        return e;
    endfunction

    task automatic step(bit rst, bit fl, logic [7:0] r8, bit rd8, logic [4:0] r5, bit rd5);
        exp_t z;
        rst_n = rst; flush = fl; req8 = r8; rdy8 = rd8; req5 = r5; rdy5 = rd5;
        // Asynchronous reset clears the outputs already on display this cycle.
        if (!rst && q.size() > 0) begin
            z = q[$];
            z.v8 = 1'b0; z.g8 = '0; z.v5 = 1'b0; z.g5 = '0;
            q[$] = z;
        end
        model_step(0, 8, rst, fl, 32'(r8), rd8);
        model_step(1, 5, rst, fl, 32'(r5), rd5);
        q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected response per cycle, compared away from the clock edge.
    initial begin : monitor
        exp_t e;
        int   enc;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (val8 !== e.v8 || gnt8 !== e.g8) begin
                    n_err++;
                    $display("FAIL arb8 t=%0t: got valid=%b gnt=%h, want valid=%b gnt=%h",
                             $time, val8, gnt8, e.v8, e.g8);
                end
                n_vec++;
                if (val5 !== e.v5 || gnt5 !== e.g5) begin
                    n_err++;
                    $display("FAIL arb5 t=%0t: got valid=%b gnt=%b, want valid=%b gnt=%b",
                             $time, val5, gnt5, e.v5, e.g5);
                end
                if (e.v5) begin
                    enc = -1;
                    for (int i = 0; i < 5; i++) if (gnt5[i]) enc = i;
                    n_vec++;
                    if (enc != e.idx5) begin
                        n_err++;
                        $display("FAIL enc5 t=%0t: got index %0d, want %0d", $time, enc, e.idx5);
                    end
                end
            end
        end
    end

    initial begin : driver
        // Reset with all requests up, then release with none.
        repeat (3) step(1'b0, 1'b0, 8'hFF, 1'b1, 5'b10001, 1'b1);
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b1, 5'b00000, 1'b1);
        step(1'b1, 1'b0, 8'h01, 1'b1, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
        // Full rotation from a fresh pointer.
        step(1'b0, 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
        repeat (10) step(1'b1, 1'b0, 8'hFF, 1'b1, 5'b10001, 1'b1);
        // Stall: hold grant 04 while requests change, then release.
        step(1'b0, 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h04, 1'b0, 5'b10001, 1'b1);
        repeat (5) step(1'b1, 1'b0, 8'h81, 1'b0, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h81, 1'b1, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
        // Sole re-request, then a second requester joins.
        repeat (4) step(1'b1, 1'b0, 8'h04, 1'b1, 5'b10001, 1'b1);
        repeat (4) step(1'b1, 1'b0, 8'h24, 1'b1, 5'b10001, 1'b1);
        // Flush while holding grant 10.
        step(1'b0, 1'b0, 8'h00, 1'b1, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h10, 1'b0, 5'b10001, 1'b1);
        step(1'b1, 1'b0, 8'h10, 1'b0, 5'b10001, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 5'b10001, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'hFF, 1'b1, 5'b10001, 1'b1);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit         r, f, d8, d5;
            logic [7:0] a8;
            logic [4:0] a5;
            r  = ($urandom_range(63) != 0);
            f  = ($urandom_range(15) == 0);
            d8 = ($urandom_range(3) != 0);
            d5 = ($urandom_range(1) != 0);
            a8 = ($urandom_range(1) != 0) ? 8'($urandom) : 8'(1 << $urandom_range(7));
            a5 = 5'($urandom);
            if ($urandom_range(7) == 0) a8 = '0;
            step(r, f, a8, d8, a5, d5);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'h00, 1'b1);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending responses, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_onehot_arb
